// File: rtl/matrix_scan_ctrl.sv
// Row-scanned 8x16 LED matrix controller with registered, active-low pin drive.
// Define MATRIX_DOUBLE_BUFFER_EN to add a back buffer published by frame-aligned swaps.
module matrix_scan_ctrl #(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [15:0] wr_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_start,
    output logic [7:0]  MATRIX_ROW,
    output logic [15:0] MATRIX_COL
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [2:0]     row_reg, row_next;
    logic           started_reg;
    logic           frame_start_reg, frame_start_next;
    logic [7:0]     matrix_row_reg;
    logic [15:0]    matrix_col_reg;
    logic           front_sel;
    logic           write_sel;
    logic [15:0]    front_row;

`ifdef MATRIX_DOUBLE_BUFFER_EN
    localparam int NBUF = 2;
    logic pending_reg;
    logic front_sel_reg;
    logic swap_cycle;
    logic swap_fire;

    // A request arriving on the swap cycle is served by that same swap.
    assign swap_cycle = started_reg && (state_reg == ST_DRIVE) &&
                        (row_reg == 3'd7) && (cnt_reg == LAST_CNT);
    assign swap_fire  = swap_cycle && (pending_reg || swap_req);
    assign swap_ack   = swap_fire;
    assign front_sel  = front_sel_reg;
    assign write_sel  = ~front_sel_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg   <= 1'b0;
            front_sel_reg <= 1'b0;
        end else begin
            if (swap_fire) begin
                pending_reg   <= 1'b0;
                front_sel_reg <= ~front_sel_reg;
            end else if (swap_req) begin
                pending_reg   <= 1'b1;
            end
        end
    end
`else
    localparam int NBUF = 1;
    logic swap_ack_reg;

    assign swap_ack  = swap_ack_reg;
    assign front_sel = 1'b0;
    assign write_sel = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swap_ack_reg <= 1'b0;
        end else begin
            swap_ack_reg <= swap_req;
        end
    end
`endif

    // Buffers must clear on reset, so they are flop arrays rather than RAM.
    logic [15:0] buf_mem [NBUF][8];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NBUF; gi++) begin : g_buf
            for (gj = 0; gj < 8; gj++) begin : g_row
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        buf_mem[gi][gj] <= '0;
                    end else if (wr_en && (wr_row == 3'(gj)) && (write_sel == 1'(gi))) begin
                        buf_mem[gi][gj] <= wr_data;
                    end
                end
            end
        end
    endgenerate

    assign front_row = buf_mem[front_sel][row_reg];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        row_next   = row_reg;
        if (!started_reg) begin
            // First edge out of reset parks on row 0 / count 0 so frame_start lines up.
            cnt_next = cnt_reg;
        end else begin
            case (state_reg)
                ST_BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_reg == LAST_CNT) begin
                        state_next = ST_BLANK;
                        cnt_next   = '0;
                        row_next   = row_reg + 3'd1;
                    end
                end
                default: state_next = ST_BLANK;
            endcase
        end
        frame_start_next = (state_next == ST_BLANK) && (row_next == 3'd0) && (cnt_next == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_BLANK;
            cnt_reg         <= '0;
            row_reg         <= '0;
            started_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            row_reg         <= row_next;
            started_reg     <= 1'b1;
            frame_start_reg <= frame_start_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            matrix_row_reg <= 8'hFF;
            matrix_col_reg <= 16'hFFFF;
        end else if (state_reg == ST_DRIVE) begin
            matrix_row_reg <= ~(8'd1 << row_reg);
            matrix_col_reg <= ~front_row;
        end else begin
            matrix_row_reg <= 8'hFF;
            matrix_col_reg <= 16'hFFFF;
        end
    end

    assign frame_start = frame_start_reg;
    assign MATRIX_ROW  = matrix_row_reg;
    assign MATRIX_COL  = matrix_col_reg;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl (SCAN_DIV=16, BLANK_CYCLES=4); cycle p is
// the p-th cycle after the first clock edge following reset release.
module tb_matrix_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_row = '0;
    logic [15:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        frame_start;
    logic [7:0]  MATRIX_ROW;
    logic [15:0] MATRIX_COL;

    matrix_scan_ctrl #(.SCAN_DIV(16), .BLANK_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_row(wr_row),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_start(frame_start), .MATRIX_ROW(MATRIX_ROW), .MATRIX_COL(MATRIX_COL)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  row;
        logic [15:0] col;
    } pin_t;

    pin_t pq[$];
    int   fsq[$];
    int   ackq[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic exp_pin(int p, logic [7:0] r, logic [15:0] c);
        pin_t e;
        e.cyc = base + 1 + p;
        e.row = r;
        e.col = c;
        pq.push_back(e);
    endtask

    task automatic exp_fs(int p);
        fsq.push_back(base + 1 + p);
    endtask

    task automatic exp_ack(int p);
        ackq.push_back(base + 1 + p);
    endtask

    task automatic at_cycle(int p);
        int tgt;
        tgt = base + 1 + p;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < tgt);
    endtask

    task automatic do_write(int p, logic [2:0] r, logic [15:0] d);
        at_cycle(p);
        wr_en = 1'b1; wr_row = r; wr_data = d;
        $display("write  p=%0d row=%0d data=%04h", p, r, d);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_swap(int p);
        at_cycle(p);
        swap_req = 1'b1;
        $display("swapreq p=%0d", p);
        @(posedge clk); #1;
        swap_req = 1'b0;
    endtask

    task automatic mid_reset(int p);
        at_cycle(p);
        #2 reset_n = 1'b0;
        #1;
        $display("reset  p=%0d row=%02h col=%04h", p, MATRIX_ROW, MATRIX_COL);
        chk("async_rst_row", 32'(MATRIX_ROW), 32'h00FF);
        chk("async_rst_col", 32'(MATRIX_COL), 32'hFFFF);
        chk("async_rst_fs", 32'(frame_start), 32'h0);
        chk("async_rst_ack", 32'(swap_ack), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = cyc;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].cyc == cyc) begin
            $display("pins   p=%0d row=%02h col=%04h exp %02h/%04h",
                     cyc - base - 1, MATRIX_ROW, MATRIX_COL, pq[0].row, pq[0].col);
            chk("pin_row", 32'(MATRIX_ROW), 32'(pq[0].row));
            chk("pin_col", 32'(MATRIX_COL), 32'(pq[0].col));
            void'(pq.pop_front());
        end
        if (frame_start === 1'b1) begin
            if (fsq.size() == 0) begin
                chk("frame_start_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                $display("fstart p=%0d", cyc - base - 1);
                chk("frame_start_cycle", 32'(cyc), 32'(fsq[0]));
                void'(fsq.pop_front());
            end
        end
        if (swap_ack === 1'b1) begin
            if (ackq.size() == 0) begin
                chk("swap_ack_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                $display("ack    p=%0d", cyc - base - 1);
                chk("swap_ack_cycle", 32'(cyc), 32'(ackq[0]));
                void'(ackq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_row", 32'(MATRIX_ROW), 32'h00FF);
        chk("rst_col", 32'(MATRIX_COL), 32'hFFFF);
        chk("rst_fs", 32'(frame_start), 32'h0);
        chk("rst_ack", 32'(swap_ack), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        base = cyc;

`ifdef MATRIX_DOUBLE_BUFFER_EN
        for (int f = 0; f < 5; f++) exp_fs(f * 128);
        exp_ack(127); exp_ack(255); exp_ack(383);
        exp_pin(1, 8'hFF, 16'hFFFF);
        exp_pin(5, 8'hFE, 16'hFFFF);
        exp_pin(40, 8'hFB, 16'hFFFF);
        exp_pin(127, 8'h7F, 16'hFFFF);
        exp_pin(128, 8'h7F, 16'hFFFF);
        exp_pin(129, 8'hFF, 16'hFFFF);
        exp_pin(160, 8'hFD, 16'hFFFF);
        for (int p = 161; p <= 164; p++) exp_pin(p, 8'hFF, 16'hFFFF);
        for (int p = 165; p <= 176; p++) exp_pin(p, 8'hFB, 16'h7FFE);
        exp_pin(177, 8'hFF, 16'hFFFF);
        exp_pin(213, 8'hDF, 16'hFFFF);
        exp_pin(293, 8'hFB, 16'hFFFF);
        exp_pin(340, 8'hFF, 16'hFFFF);
        exp_pin(341, 8'hDF, 16'h0000);
        exp_pin(352, 8'hDF, 16'h0000);
        exp_pin(353, 8'hFF, 16'hFFFF);
        exp_pin(421, 8'hFB, 16'h7FFE);
        exp_pin(469, 8'hDF, 16'hFFFF);

        do_write(10, 3'd2, 16'h8001);
        do_swap(20);
        do_swap(140);
        do_swap(150);
        do_swap(200);
        do_write(255, 3'd5, 16'hFFFF);
        do_swap(383);
        do_swap(580);
        mid_reset(584);

        exp_fs(0); exp_fs(128);
        exp_pin(5, 8'hFE, 16'hFFFF);
        exp_pin(40, 8'hFB, 16'hFFFF);
        exp_pin(85, 8'hDF, 16'hFFFF);
        at_cycle(140);
`else
        exp_fs(0); exp_fs(128); exp_fs(256);
        exp_ack(151); exp_ack(161); exp_ack(171);
        exp_pin(1, 8'hFF, 16'hFFFF);
        exp_pin(5, 8'hFE, 16'hFFFF);
        exp_pin(20, 8'hFF, 16'hFFFF);
        exp_pin(21, 8'hFD, 16'hFFFF);
        exp_pin(127, 8'h7F, 16'hFFFF);
        exp_pin(128, 8'h7F, 16'hFFFF);
        exp_pin(129, 8'hFF, 16'hFFFF);
        exp_pin(132, 8'hFF, 16'hFFFF);
        exp_pin(133, 8'hFE, 16'hFFFF);
        exp_pin(135, 8'hFE, 16'hFFFF);
        exp_pin(136, 8'hFE, 16'hFFFE);
        exp_pin(144, 8'hFE, 16'hFFFE);
        exp_pin(145, 8'hFF, 16'hFFFF);
        exp_pin(201, 8'hEF, 16'hFFFF);
        exp_pin(202, 8'hEF, 16'hFF0F);
        exp_pin(261, 8'hFE, 16'hFFFE);
        exp_pin(326, 8'hEF, 16'hFF0F);

        do_write(134, 3'd0, 16'h0001);
        do_swap(150);
        do_swap(160);
        do_swap(170);
        do_write(200, 3'd4, 16'h00F0);
        mid_reset(328);

        exp_fs(0); exp_fs(128);
        exp_pin(5, 8'hFE, 16'hFFFF);
        exp_pin(69, 8'hEF, 16'hFFFF);
        exp_pin(133, 8'hFE, 16'hFFFF);
        at_cycle(140);
`endif

        while (pq.size() > 0) begin
            chk("pin_missing", 32'(cyc), 32'(pq[0].cyc));
            void'(pq.pop_front());
        end
        while (fsq.size() > 0) begin
            chk("frame_start_missing", 32'(cyc), 32'(fsq[0]));
            void'(fsq.pop_front());
        end
        while (ackq.size() > 0) begin
            chk("swap_ack_missing", 32'(cyc), 32'(ackq[0]));
            void'(ackq.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
